// File: rtl/activation_mem_ctrl.sv
// Activation memory sequencer: loads a SIZE x SIZE tile from a valid/ready
// stream, then streams SIZE row reads to the systolic array pre-load path.
module activation_mem_ctrl #(
    parameter int SIZE             = 8,
    parameter int MEM_SIZE         = SIZE * SIZE,
    parameter int WRITE_ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter int READ_ADDR_WIDTH  = $clog2(SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        In_valid,
    output logic                        In_ready,
    input  logic [6:0]                  Activation_in,
    input  logic                        Start,
    input  logic                        Reuse,
    output logic [6:0]                  Activation,
    output logic [WRITE_ADDR_WIDTH-1:0] Wr_Addr,
    output logic                        Wr_en,
    output logic                        Rd_en,
    output logic [READ_ADDR_WIDTH-1:0]  Rd_Addr,
    output logic                        Act_valid,
    output logic                        Busy,
    output logic                        Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [WRITE_ADDR_WIDTH-1:0] LAST_W =
        WRITE_ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [READ_ADDR_WIDTH-1:0] LAST_R =
        READ_ADDR_WIDTH'(SIZE - 1);

    state_t                        r_state;
    logic [WRITE_ADDR_WIDTH-1:0]   r_wcnt;
    logic [6:0]                    r_act;
    logic [WRITE_ADDR_WIDTH-1:0]   r_wr_addr;
    logic                          r_wr_en;
    logic                          r_rd_en;
    logic [READ_ADDR_WIDTH-1:0]    r_rd_addr;
    logic                          r_act_valid;
    logic                          w_accept;
    logic                          w_last_beat;

    assign In_ready    = !rst && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_accept    = In_valid && In_ready;
    assign w_last_beat = w_accept && (r_wcnt == LAST_W);

    assign Activation = r_act;
    assign Wr_Addr    = r_wr_addr;
    assign Wr_en      = r_wr_en;
    assign Rd_en      = r_rd_en;
    assign Rd_Addr    = r_rd_addr;
    assign Act_valid  = r_act_valid;
    assign Busy       = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign Done       = (r_state == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_act       <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_act_valid <= 1'b0;
        end else begin
            // memory output is registered, so valid trails the read by one
            r_act_valid <= r_rd_en;
            r_wr_en     <= w_accept;
            if (w_accept) begin
                r_act     <= Activation_in;
                r_wr_addr <= r_wcnt;
                r_wcnt    <= w_last_beat ? '0 : r_wcnt + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= w_last_beat ? S_FULL : S_LOAD;
                end
                S_LOAD: begin
                    if (w_last_beat)
                        r_state <= S_FULL;
                end
                S_FULL: begin
                    if (Start) begin
                        r_state   <= S_STREAM;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                S_STREAM: begin
                    if (r_rd_addr == LAST_R) begin
                        r_state   <= S_DRAIN;
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= Reuse ? S_FULL : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_mem_ctrl.sv
// Randomized bench for activation_mem_ctrl against a time-offset reference
// model: tile fill counted in beats, streaming timed from the Start edge.
module tb_activation_mem_ctrl;

    localparam int SIZE = 8;
    localparam int MEM  = SIZE * SIZE;
    localparam int WA   = $clog2(MEM);
    localparam int RA   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst;
    logic          In_valid;
    logic          In_ready;
    logic [6:0]    Activation_in;
    logic          Start;
    logic          Reuse;
    logic [6:0]    Activation;
    logic [WA-1:0] Wr_Addr;
    logic          Wr_en;
    logic          Rd_en;
    logic [RA-1:0] Rd_Addr;
    logic          Act_valid;
    logic          Busy;
    logic          Done;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         cyc = 0;
    bit         s_vld;
    int         s;
    bit         tile;
    int         loaded;
    bit         m_wen;
    int         m_waddr;
    logic [6:0] m_act;

    activation_mem_ctrl #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .In_valid     (In_valid),
        .In_ready     (In_ready),
        .Activation_in(Activation_in),
        .Start        (Start),
        .Reuse        (Reuse),
        .Activation   (Activation),
        .Wr_Addr      (Wr_Addr),
        .Wr_en        (Wr_en),
        .Rd_en        (Rd_en),
        .Rd_Addr      (Rd_Addr),
        .Act_valid    (Act_valid),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // true when the cycle offset from the last accepted Start is in [lo,hi]
    function automatic bit in_rng(input int lo, input int hi);
        return s_vld && (cyc - s) >= lo && (cyc - s) <= hi;
    endfunction

    function automatic void model_reset();
        s_vld   = 1'b0;
        s       = 0;
        tile    = 1'b0;
        loaded  = 0;
        m_wen   = 1'b0;
        m_waddr = 0;
        m_act   = '0;
    endfunction

    task automatic check_all();
        int  d;
        bit  rd;
        d  = cyc - s;
        rd = in_rng(0, SIZE - 1);
        chk("In_ready", 32'(In_ready),
            32'(!rst && !tile && !in_rng(0, SIZE)));
        chk("Wr_en", 32'(Wr_en), 32'(m_wen));
        chk("Wr_Addr", 32'(Wr_Addr), 32'(m_waddr));
        chk("Activation", 32'(Activation), 32'(m_act));
        chk("Rd_en", 32'(Rd_en), 32'(rd));
        chk("Rd_Addr", 32'(Rd_Addr), rd ? 32'(d) : 32'd0);
        chk("Act_valid", 32'(Act_valid), 32'(in_rng(1, SIZE)));
        chk("Done", 32'(Done), 32'(in_rng(SIZE, SIZE)));
        chk("Busy", 32'(Busy), 32'(in_rng(0, SIZE)));
        chk("wr_rd_excl", 32'(Wr_en && Rd_en), 32'd0);
    endtask

    task automatic cycle(input bit v, input logic [6:0] dat,
                         input bit st, input bit ru);
        bit busy_prev;
        bit ready_prev;
        bit drain_prev;
        In_valid      = v;
        Activation_in = dat;
        Start         = st;
        Reuse         = ru;
        busy_prev  = in_rng(0, SIZE);
        drain_prev = in_rng(SIZE, SIZE);
        ready_prev = !tile && !busy_prev;
        @(posedge clk);
        cyc++;
        if (drain_prev && !ru) begin
            tile = 1'b0;
        end else if (tile && !busy_prev && st) begin
            s     = cyc;
            s_vld = 1'b1;
        end
        if (v && ready_prev) begin
            m_wen   = 1'b1;
            m_waddr = loaded;
            m_act   = dat;
            loaded++;
            if (loaded == MEM) begin
                loaded = 0;
                tile   = 1'b1;
            end
        end else begin
            m_wen = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
        rst = 1'b0;
        #1;
        check_all();
    endtask

    task automatic load_tile();
        for (int i = 0; i < MEM; i++)
            cycle(1'b1, 7'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        In_valid      = 1'b1;
        Start         = 1'b0;
        Reuse         = 1'b0;
        Activation_in = '0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        #1;
        check_all();

        // reset in the middle of a load with In_valid held high
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 7'($urandom), 1'b0, 1'b0);
        In_valid = 1'b1;
        do_reset();

        // Start in IDLE ignored, then full continuous load with stray Starts
        cycle(1'b0, 7'd0, 1'b1, 1'b0);
        cycle(1'b0, 7'd0, 1'b1, 1'b0);
        for (int i = 0; i < MEM; i++)
            cycle(1'b1, 7'(i), (i % 7) == 3, 1'b0);
        cycle(1'b1, 7'h55, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 7'd0, 1'b0, 1'b0);

        // gapped load with a 1,0,0,1 valid pattern
        for (int i = 0; i < 200 && !tile; i++)
            cycle((i % 4) == 0 || (i % 4) == 3, 7'($urandom), 1'b0, 1'b0);
        chk("gapped_full", 32'(In_ready), 32'd0);

        // stream with reuse, then restream without reuse
        cycle(1'b0, 7'd0, 1'b1, 1'b1);
        for (int i = 0; i < SIZE + 1; i++)
            cycle(1'b1, 7'($urandom), 1'b0, 1'b1);
        cycle(1'b1, 7'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < SIZE + 4; i++)
            cycle(1'b1, 7'($urandom), 1'b0, 1'b0);

        // abort during the 4th STREAM cycle
        do_reset();
        load_tile();
        cycle(1'b0, 7'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 7'd0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 7'd0, 1'b1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 2) != 0, 7'($urandom),
                      $urandom_range(0, 3) == 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/activation_mem_ctrl.md
# activation_mem_ctrl

Sequencer for the activation memory feeding the systolic array. It accepts a stream of 7-bit activations over a valid/ready handshake and writes them into the activation memory in address order. On a start command it issues SIZE row reads so one SIZE×7 activation vector per cycle reaches the pre-load path, then signals completion. It sits between the host/DMA activation stream and the activation memory. It is the only block that drives the memory's write and read ports.

## Interface
Parameters:
- SIZE, 8, systolic array dimension; memory holds SIZE banks × SIZE rows
- MEM_SIZE, SIZE*SIZE, activations per tile
- WRITE_ADDR_WIDTH, $clog2(MEM_SIZE), write address width
- READ_ADDR_WIDTH, $clog2(SIZE), read (row) address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- In_valid  in  1  activation beat valid
- In_ready  out  1  controller accepts a beat this cycle
- Activation_in  in  7  activation data
- Start  in  1  request to stream the loaded tile
- Reuse  in  1  keep the tile after streaming (sampled in DRAIN)
- Activation  out  7  write data to memory (registered)
- Wr_Addr  out  WRITE_ADDR_WIDTH  write address (registered)
- Wr_en  out  1  memory write enable (registered)
- Rd_en  out  1  memory read enable (registered)
- Rd_Addr  out  READ_ADDR_WIDTH  memory row address (registered)
- Act_valid  out  1  memory output vector valid this cycle
- Busy  out  1  high in STREAM and DRAIN
- Done  out  1  one-cycle pulse at the end of streaming

## Operation
- States: IDLE, LOAD, FULL, STREAM, DRAIN.
- In_ready = !rst && (state==IDLE || state==LOAD). It is combinational from state only and never depends on In_valid.
- Beat accept = In_valid && In_ready. Beat n (0-based since the last IDLE) goes to Wr_Addr n: Activation<=Activation_in, Wr_Addr<=wcnt, Wr_en<=1, wcnt<=wcnt+1. On a cycle with no accept, Wr_en<=0 and Activation/Wr_Addr hold.
- IDLE -> LOAD on the first accept. LOAD -> FULL on the accept with wcnt==MEM_SIZE-1. On that transition wcnt wraps to 0.
- Start is sampled only in FULL. In IDLE, LOAD, STREAM and DRAIN it is ignored and not latched.
- FULL + Start -> STREAM. STREAM lasts exactly SIZE cycles with Rd_en=1 and Rd_Addr=0,1,…,SIZE-1. Rd_Addr is a READ_ADDR_WIDTH counter; its wrap from SIZE-1 to 0 ends STREAM.
- STREAM -> DRAIN after the Rd_Addr=SIZE-1 cycle. DRAIN lasts one cycle.
- DRAIN -> FULL if Reuse=1 (tile kept, new Start accepted). Otherwise DRAIN -> IDLE (tile discarded, next load overwrites from address 0).
- Act_valid = Rd_en delayed one cycle, because the memory output is registered.
- Done = 1 in the DRAIN cycle, coincident with the last Act_valid.
- Wr_en and Rd_en are never high in the same cycle. The memory gives write priority, so overlap would corrupt reads.

## Timing
- Reset (asynchronous): state=IDLE, wcnt=0, Activation=0, Wr_Addr=0, Wr_en=0, Rd_en=0, Rd_Addr=0, Act_valid=0, Busy=0, Done=0, In_ready=0 while rst=1.
- Write latency: a beat accepted at edge k has Wr_en=1 during cycle k→k+1. The memory captures it at edge k+1.
- Continuous In_valid loads a tile in MEM_SIZE cycles. The final write is issued in the first FULL cycle, so In_ready is already 0 in that cycle.
- Start sampled at edge s: Rd_en=1, Rd_Addr=0 from edge s to s+1. Act_valid=1 from edge s+1 to s+SIZE+1. Done is high in the cycle s+SIZE to s+SIZE+1.
- Start in the first FULL cycle is legal. The last write lands at the same edge that raises Rd_en, so there is no overlap.
- Start-to-Done: SIZE+1 cycles. Back-to-back reuse: minimum Start spacing is SIZE+2 cycles (STREAM, DRAIN, one FULL cycle).
- rst mid-operation: all outputs clear immediately and the FSM restarts in IDLE. Memory contents are treated as invalid, so a full reload is required.

## Test plan
- Reset: assert rst mid-LOAD with In_valid=1 -> In_ready=0, Wr_en=0 immediately. After release, In_ready=1 and wcnt=0 (next beat writes to Wr_Addr 0).
- Full load, SIZE=8: 64 consecutive beats of value n&0x7F -> Wr_en high 64 consecutive cycles, Wr_Addr 0..63 with Activation=n. In_ready=0 from the cycle after the 64th accept.
- Gapped load: In_valid toggling 1,0,0,1 pattern -> Wr_en only after accepted beats, Wr_Addr contiguous 0..63, no skipped or duplicated addresses.
- Stream: Start pulses in IDLE and LOAD are ignored. Start in FULL -> Rd_en 8 cycles with Rd_Addr 0..7, Act_valid 8 cycles lagging by 1, Busy high 9 cycles. Done is a single pulse with the 8th Act_valid. The FSM then returns to IDLE and In_ready=1.
- Reuse: Reuse=1 in DRAIN -> FULL, In_ready=0. A second Start streams again with Rd_Addr 0..7 and no Wr_en.
- Abort: rst at the 4th STREAM cycle -> Rd_en, Act_valid and Busy drop immediately, Done never pulses. A subsequent Start is ignored until 64 new beats are loaded.
